// File: rtl/cpu_cycle_ctrl.sv
// cpu_cycle_ctrl: multicycle sequencer for the MIPS core.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK.
// Bus states stretch while Avalon waitrequest is high. The block also drives the
// register-file write strobe, destination index and link-data select, and stops
// the CPU when an instruction retires with pc_next == HALT_ADDR.
// Ports:
//   clk, reset    system clock; synchronous active-high reset
//   instr         instruction word from IR (valid DECODE onward)
//   waitrequest   Avalon stall for the current fetch/load/store
//   pc_next       next PC from datapath (valid in the retire cycle)
//   state         current sequencer state (HALTED = 3'b101)
//   instr_read, ir_en, data_read, data_write   bus / IR strobes
//   reg_write, write_reg, link_sel             register-file control
//   pc_en         PC update strobe, once per retired instruction
//   active        high while the CPU runs
module cpu_cycle_ctrl #(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        waitrequest,
  input  logic [31:0] pc_next,
  output logic [2:0]  state,
  output logic        instr_read,
  output logic        ir_en,
  output logic        data_read,
  output logic        data_write,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic        link_sel,
  output logic        pc_en,
  output logic        active
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0]  OP_RTYPE  = 6'b000000;
  localparam logic [OP_W-1:0]  OP_REGIMM = 6'b000001;
  localparam logic [OP_W-1:0]  OP_JAL    = 6'b000011;
  localparam logic [OP_W-1:0]  OP_SB     = 6'b101000;
  localparam logic [OP_W-1:0]  OP_SH     = 6'b101001;
  localparam logic [OP_W-1:0]  OP_SW     = 6'b101011;

  localparam logic [OP_W-1:0]  FN_JR     = 6'b001000;
  localparam logic [OP_W-1:0]  FN_JALR   = 6'b001001;
  localparam logic [OP_W-1:0]  FN_MTHI   = 6'b010001;
  localparam logic [OP_W-1:0]  FN_MTLO   = 6'b010011;

  localparam logic [REG_W-1:0] RT_BLTZAL = 5'b10000;
  localparam logic [REG_W-1:0] RT_BGEZAL = 5'b10001;
  localparam logic [REG_W-1:0] REG_RA    = 5'd31;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALTED = 3'b101
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OP_W-1:0]  opcode;
  logic [OP_W-1:0]  funct;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;

  logic is_load;
  logic is_store;
  logic is_jal;
  logic is_jalr;
  logic is_regimm_link;
  logic writes_reg;

  assign opcode = instr[31:26];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];

  // rs and shamt do not affect sequencing
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[25:21], instr[10:6]};

  // Instruction classification
  always_comb begin
    is_load        = (opcode >= 6'b100000) && (opcode <= 6'b100110);
    is_store       = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
    is_jal         = (opcode == OP_JAL);
    is_jalr        = (opcode == OP_RTYPE) && (funct == FN_JALR);
    is_regimm_link = (opcode == OP_REGIMM) && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL));
    writes_reg     = 1'b0;
    if (opcode == OP_RTYPE) begin
      writes_reg = !((funct == FN_JR) || (funct == FN_MTHI) || (funct == FN_MTLO) ||
                     ((funct >= 6'b011000) && (funct <= 6'b011011)));
    end else if ((opcode >= 6'b001001) && (opcode <= 6'b001111)) begin
      writes_reg = 1'b1;
    end else if (is_load || is_jal || is_regimm_link) begin
      writes_reg = 1'b1;
    end
  end

  // Destination index and link-data select
  always_comb begin
    write_reg = rt;
    if (is_jal || is_regimm_link) begin
      write_reg = REG_RA;
    end else if (opcode == OP_RTYPE) begin
      write_reg = (is_jalr && (rd == '0)) ? REG_RA : rd;
    end
    link_sel = is_jal || is_jalr || is_regimm_link;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes
  always_comb begin
    state_d    = state_q;
    instr_read = 1'b0;
    ir_en      = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
    reg_write  = 1'b0;
    pc_en      = 1'b0;

    case (state_q)
      S_FETCH: begin
        instr_read = 1'b1;
        if (!waitrequest) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (writes_reg) begin
          state_d = S_WB;
        end else begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        data_read  = is_load;
        data_write = is_store && !is_load;
        if (!waitrequest) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase

    // Retiring into the halt address stops the CPU after this cycle
    if (pc_en && (pc_next == HALT_ADDR)) begin
      state_d = S_HALTED;
    end

    // Reset drops any pending strobe in the same cycle
    if (reset) begin
      instr_read = 1'b0;
      ir_en      = 1'b0;
      data_read  = 1'b0;
      data_write = 1'b0;
      reg_write  = 1'b0;
      pc_en      = 1'b0;
    end
  end

  assign state  = state_q;
  assign active = (state_q != S_HALTED);

endmodule

// File: tb/tb_cpu_cycle_ctrl.sv
// Self-checking bench for cpu_cycle_ctrl: an instruction-level model expands each
// instruction into its expected cycle trace; a negedge process compares every cycle.
module tb_cpu_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        waitrequest;
  logic [31:0] pc_next;
  logic [2:0]  state;
  logic        instr_read, ir_en, data_read, data_write, reg_write, link_sel, pc_en, active;
  logic [4:0]  write_reg;

  cpu_cycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .waitrequest(waitrequest), .pc_next(pc_next),
    .state(state), .instr_read(instr_read), .ir_en(ir_en), .data_read(data_read),
    .data_write(data_write), .reg_write(reg_write), .write_reg(write_reg),
    .link_sel(link_sel), .pc_en(pc_en), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [6:0] strb;   // instr_read, ir_en, data_read, data_write, reg_write, pc_en, active
    logic       chk_wr;
    logic [4:0] wr;
    logic       ls;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_total = 0, dr_total = 0, dw_total = 0, rw_total = 0, pe_total = 0, strb_total = 0;

  // Per-cycle comparison against the model trace
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] got;
    got = {instr_read, ir_en, data_read, data_write, reg_write, pc_en, active};
    cyc_total  = cyc_total + 1;
    dr_total   = dr_total + int'(data_read);
    dw_total   = dw_total + int'(data_write);
    rw_total   = rw_total + int'(reg_write);
    pe_total   = pe_total + int'(pc_en);
    strb_total = strb_total + int'(instr_read | ir_en | data_read | data_write | reg_write | pc_en);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec = n_vec + 1;
      if (state !== e.st || got !== e.strb ||
          (e.chk_wr && (write_reg !== e.wr || link_sel !== e.ls))) begin
        n_bad = n_bad + 1;
        $display("FAIL cycle t=%0t: state/strobes/wr/link got %b/%b/%0d/%b need %b/%b/%0d/%b",
                 $time, state, got, write_reg, link_sel, e.st, e.strb, e.wr, e.ls);
      end
    end
  end

  // Model: instruction classification straight from the ISA rules
  function automatic bit m_load(input logic [31:0] iw);
    int op = int'(iw[31:26]);
    return op >= 32 && op <= 38;
  endfunction

  function automatic bit m_store(input logic [31:0] iw);
    int op = int'(iw[31:26]);
    return op == 40 || op == 41 || op == 43;
  endfunction

  function automatic bit m_writes(input logic [31:0] iw);
    int op = int'(iw[31:26]);
    int fn = int'(iw[5:0]);
    int t  = int'(iw[20:16]);
    case (op)
      0:       return !(fn == 8 || fn == 17 || fn == 19 || (fn >= 24 && fn <= 27));
      1:       return t == 16 || t == 17;
      3:       return 1'b1;
      default: return (op >= 9 && op <= 15) || (op >= 32 && op <= 38);
    endcase
  endfunction

  function automatic bit m_link(input logic [31:0] iw);
    int op = int'(iw[31:26]);
    return op == 3 || (op == 0 && iw[5:0] == 6'd9) ||
           (op == 1 && (iw[20:16] == 5'd16 || iw[20:16] == 5'd17));
  endfunction

  function automatic logic [4:0] m_dest(input logic [31:0] iw);
    if (iw[31:26] == 6'd0) begin
      if (iw[5:0] == 6'd9 && iw[15:11] == 5'd0) return 5'd31;
      return iw[15:11];
    end
    if (m_link(iw)) return 5'd31;
    return iw[20:16];
  endfunction

  task automatic push(input logic [2:0] st, input logic [5:0] s, input logic act,
                      input logic cw, input logic [4:0] wr, input logic ls);
    exp_t e;
    e.st = st; e.strb = {s, act}; e.chk_wr = cw; e.wr = wr; e.ls = ls;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One reset cycle from the given state: no strobes, then FETCH
  task automatic reset_cycle(input logic [2:0] st, input logic act);
    reset = 1'b1;
    push(st, 6'b000000, act, 1'b0, 5'd0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  // Run one instruction: fw fetch stalls, mw memory stalls, optional halt on retire,
  // optional reset injected at fetch cycle rf or memory cycle rm (-1 = none)
  task automatic run_instr(input logic [31:0] iw, input int fw, input int mw,
                           input bit halt, input int rf, input int rm);
    bit ld, sto, wr, retire_exec;
    ld  = m_load(iw);
    sto = m_store(iw);
    wr  = m_writes(iw);
    retire_exec = !ld && !sto && !wr;
    instr   = iw;
    pc_next = halt ? 32'h0 : 32'h0040_0010;
    for (int k = 0; k <= fw; k++) begin
      waitrequest = (k < fw);
      if (k == rf) begin
        reset_cycle(3'b000, 1'b1);
        waitrequest = 1'b0;
        return;
      end
      push(3'b000, {1'b1, (k == fw), 4'b0000}, 1'b1, 1'b0, 5'd0, 1'b0);
      tick();
    end
    waitrequest = 1'b0;
    push(3'b001, 6'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    push(3'b010, {5'b0, retire_exec}, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    if (!retire_exec) begin
      if (ld || sto) begin
        for (int k = 0; k <= mw; k++) begin
          waitrequest = (k < mw);
          if (k == rm) begin
            reset_cycle(3'b011, 1'b1);
            waitrequest = 1'b0;
            return;
          end
          push(3'b011, {2'b00, ld, sto, 1'b0, (sto && k == mw)}, 1'b1, 1'b0, 5'd0, 1'b0);
          tick();
        end
        waitrequest = 1'b0;
      end
      if (!sto) begin
        push(3'b100, 6'b000011, 1'b1, 1'b1, m_dest(iw), m_link(iw));
        tick();
      end
    end
  endtask

  task automatic halted_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      waitrequest = 1'($urandom_range(0, 1));
      instr       = $urandom;
      push(3'b101, 6'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
    end
    waitrequest = 1'b0;
  endtask

  task automatic pin(input string name, input int got, input int need);
    n_vec = n_vec + 1;
    if (got != need) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d need %0d", name, got, need);
    end
  endtask

  int c0, d0, w0, r0, p0, s0;

  initial begin
    reset = 1'b1; waitrequest = 1'b0; instr = 32'h0; pc_next = 32'h0040_0000;
    tick();
    reset_cycle(3'b000, 1'b1);

    // ADDIU $2,$0,5
    c0 = cyc_total; r0 = rw_total;
    run_instr(32'h2402_0005, 0, 0, 1'b0, -1, -1);
    pin("addiu_cycles", cyc_total - c0, 4);
    pin("addiu_reg_write", rw_total - r0, 1);

    // LW $3,0($4) with 3 memory stalls
    c0 = cyc_total; d0 = dr_total;
    run_instr(32'h8C83_0000, 0, 3, 1'b0, -1, -1);
    pin("lw_cycles", cyc_total - c0, 8);
    pin("lw_data_read", dr_total - d0, 4);

    // SW with fetch and memory stalls
    r0 = rw_total; w0 = dw_total; p0 = pe_total;
    run_instr(32'hAC83_0000, 2, 1, 1'b0, -1, -1);
    pin("sw_reg_write", rw_total - r0, 0);
    pin("sw_data_write", dw_total - w0, 2);
    pin("sw_pc_en", pe_total - p0, 1);

    run_instr(32'h0080_0009, 0, 0, 1'b0, -1, -1);  // JALR rd=0
    run_instr(32'h0490_0000, 0, 0, 1'b0, -1, -1);  // BLTZAL
    run_instr(32'h0491_0000, 1, 0, 1'b0, -1, -1);  // BGEZAL
    run_instr(32'h0C00_0010, 0, 0, 1'b0, -1, -1);  // JAL
    run_instr(32'h00A4_2821, 0, 0, 1'b0, -1, -1);  // ADDU $5
    run_instr(32'h0080_3809, 0, 0, 1'b0, -1, -1);  // JALR rd=7
    run_instr(32'h0085_0018, 0, 0, 1'b0, -1, -1);  // MULT
    run_instr(32'h1085_0003, 0, 0, 1'b0, -1, -1);  // BEQ
    run_instr(32'hFC00_0000, 0, 0, 1'b0, -1, -1);  // unknown opcode
    run_instr(32'h80A6_0004, 2, 2, 1'b0, -1, -1);  // LB $6

    // Reset during a fetch stall, then during a load stall
    run_instr(32'h2402_0005, 5, 0, 1'b0, 2, -1);
    run_instr(32'h2402_0005, 0, 0, 1'b0, -1, -1);
    run_instr(32'h8C83_0000, 0, 4, 1'b0, -1, 2);
    run_instr(32'h2402_0005, 0, 0, 1'b0, -1, -1);

    // JR $31 to address zero halts; stays halted for 20 cycles
    run_instr(32'h03E0_0008, 0, 0, 1'b1, -1, -1);
    s0 = strb_total;
    halted_cycles(20);
    pin("halt_strobes", strb_total - s0, 0);
    pin("halt_state", int'(state), 5);
    pin("halt_active", int'(active), 0);
    reset_cycle(3'b101, 1'b0);

    // A register-writing instruction still writes back when it halts
    r0 = rw_total;
    run_instr(32'h0C00_0010, 0, 0, 1'b1, -1, -1);
    halted_cycles(3);
    pin("jal_halt_reg_write", rw_total - r0, 1);
    reset_cycle(3'b101, 1'b0);
    run_instr(32'hAC83_0000, 0, 0, 1'b1, -1, -1);  // store halting from MEM
    halted_cycles(2);
    reset_cycle(3'b101, 1'b0);
    run_instr(32'h2402_0005, 0, 0, 1'b0, -1, -1);

    if (exp_q.size() != 0) begin
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL trace_drain: got %0d pending need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
